// File: rtl/iomem_dbg_pkg.sv
// Shared definitions for the iomem debug master: FSM state encoding and the
// command/reply byte values of the host protocol.
package iomem_dbg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StResp
  } state_e;

  localparam logic [7:0] OpWrite     = 8'h57;  // 'W'
  localparam logic [7:0] OpRead      = 8'h52;  // 'R'
  localparam logic [7:0] RespOk      = 8'h4B;  // 'K'
  localparam logic [7:0] RespBad     = 8'h3F;  // '?'
  localparam logic [7:0] RespTimeout = 8'h54;  // 'T'

endpackage

// File: rtl/iomem_dbg_txser.sv
// Response serializer: holds up to four reply bytes and presents them MSB
// first on a valid/ready byte interface.
//   clk, resetn    clock, synchronous active-low reset
//   load_i         capture load_data_i and start sending (only while idle)
//   load_data_i    reply word; single-byte replies sit in [31:24]
//   load_four_i    1: send all four bytes, 0: send only [31:24]
//   tx_ready_i     sink accepts tx_data_o
//   tx_data_o      current byte
//   tx_valid_o     tx_data_o valid
//   last_o         final byte is being handed over this cycle
module iomem_dbg_txser (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        load_four_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        last_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  left_q, left_d;   // bytes still to send after the current one
  logic        valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = load_data_i;
      left_d  = load_four_i ? 2'd3 : 2'd0;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready_i) begin
      if (left_q == 2'd0) begin
        valid_d = 1'b0;
      end else begin
        shift_d = {shift_q[23:0], 8'h00};
        left_d  = left_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o  = shift_q[31:24];
  assign tx_valid_o = valid_q;
  assign last_o     = valid_q && tx_ready_i && (left_q == 2'd0);

endmodule

// File: rtl/iomem_dbg_master.sv
// Byte-stream to iomem bus initiator. Host command bytes arrive on rx, one
// 32-bit iomem read or write is issued, and status/data bytes leave on tx.
//   'W' A3 A2 A1 A0 D3 D2 D1 D0 -> write, reply 'K'
//   'R' A3 A2 A1 A0             -> read, reply R3 R2 R1 R0
//   any other opcode            -> reply '?', no bus cycle
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready        command byte input
//   tx_data/tx_valid/tx_ready        response byte output
//   iomem_valid/ready/wstrb/addr/wdata/rdata   iomem initiator port
//   busy                             high whenever not idle
// Optional: define IOMEM_DBG_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles without iomem_ready and reply 'T'.
module iomem_dbg_master
  import iomem_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_write_q, is_write_d;

  logic        ser_load;
  logic [31:0] ser_data;
  logic        ser_four;
  logic        ser_last;
  logic        tmo_expire;

`ifdef IOMEM_DBG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counter holds the number of BUS cycles already elapsed, so it is zero on
  // BUS entry and the last allowed cycle is TIMEOUT_CYCLES-1.
  assign tmo_expire = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == StBus) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    ser_load   = 1'b0;
    ser_data   = '0;
    ser_four   = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          cnt_d = 2'd0;
          if (rx_data == OpWrite || rx_data == OpRead) begin
            is_write_d = (rx_data == OpWrite);
            state_d    = StAddr;
          end else begin
            ser_load = 1'b1;
            ser_data = {RespBad, 24'h0};
            state_d  = StResp;
          end
        end
      end
      StAddr: begin
        if (rx_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Word address only: low two bits dropped on the last byte.
            addr_d  = {addr_q[23:0], rx_data[7:2], 2'b00};
            state_d = is_write_q ? StData : StBus;
          end else begin
            addr_d = {addr_q[23:0], rx_data};
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          cnt_d   = cnt_q + 2'd1;
          wdata_d = {wdata_q[23:0], rx_data};
          if (cnt_q == 2'd3) begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // A ready coinciding with expiry completes normally.
        if (iomem_ready) begin
          ser_load = 1'b1;
          ser_four = !is_write_q;
          ser_data = is_write_q ? {RespOk, 24'h0} : iomem_rdata;
          state_d  = StResp;
        end else if (tmo_expire) begin
          ser_load = 1'b1;
          ser_data = {RespTimeout, 24'h0};
          state_d  = StResp;
        end
      end
      StResp: begin
        if (ser_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
    end
  end

  iomem_dbg_txser u_txser (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (ser_load),
    .load_data_i (ser_data),
    .load_four_i (ser_four),
    .tx_ready_i  (tx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .last_o      (ser_last)
  );

  // Gated by resetn so the port reads 0 while reset is held.
  assign rx_ready = resetn &&
                    (state_q == StIdle || state_q == StAddr || state_q == StData);

  // Leaving BUS the cycle after ready guarantees valid is never held into a
  // second ready.
  assign iomem_valid = (state_q == StBus);
  assign iomem_wstrb = (state_q == StBus && is_write_q) ? 4'hF : 4'h0;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_iomem_dbg_master.sv
module tb_iomem_dbg_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  iomem_dbg_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];

  int          resp_delay = 0;   // -1: responder never answers
  logic        tx_hold = 1'b0;
  int          txn_count = 0;
  int          last_len = 0;
  bit          in_txn = 1'b0;
  int          cyc = 0;
  logic [31:0] cur_rdata = 32'h0;

  // Bus responder and bus-side scoreboard.
  always @(negedge clk) begin
    bus_t b;
    if (iomem_ready) check("valid_drop", 32'(iomem_valid), 32'd0);
    iomem_ready = 1'b0;
    if (iomem_valid && resetn) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        cyc = 0;
        txn_count++;
        check("bus_pending", 32'(bus_q.size() > 0), 32'd1);
        if (bus_q.size() > 0) begin
          b = bus_q.pop_front();
          check("bus_addr", iomem_addr, b.addr);
          check("bus_wstrb", 32'(iomem_wstrb), 32'(b.wstrb));
          if (b.wstrb == 4'hF) check("bus_wdata", iomem_wdata, b.wdata);
          cur_rdata = b.rdata;
        end
      end
      if (resp_delay >= 0 && cyc == resp_delay) begin
        iomem_ready = 1'b1;
        iomem_rdata = cur_rdata;
      end
      cyc++;
    end else if (in_txn) begin
      in_txn = 1'b0;
      last_len = cyc;
    end
  end

  // Tx sink and response scoreboard.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    tx_ready = !tx_hold;
    if (resetn && prev_stall) begin
      check("tx_hold_valid", 32'(tx_valid), 32'd1);
      check("tx_hold_data", 32'(tx_data), 32'(prev_data));
    end
    if (resetn && tx_valid && tx_ready) begin
      check("tx_pending", 32'(tx_q.size() > 0), 32'd1);
      if (tx_q.size() > 0) begin
        e = tx_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(e));
      end
    end
    prev_stall = resetn && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    bit  acc;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      acc = rx_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 500);
    check("rx_accept", 32'(acc), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit exp_resp);
    bus_q.push_back('{addr: {a[31:2], 2'b00}, wdata: d, wstrb: 4'hF, rdata: 32'h0});
    if (exp_resp) tx_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input bit exp_data);
    bus_q.push_back('{addr: {a[31:2], 2'b00}, wdata: 32'h0, wstrb: 4'h0, rdata: rd});
    if (exp_data) for (int i = 3; i >= 0; i--) tx_q.push_back(rd[i*8 +: 8]);
    send_byte(8'h52);
    send_word(a);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || tx_q.size() != 0 || in_txn) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy || tx_q.size() != 0 || in_txn), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    check("rst_wstrb", 32'(iomem_wstrb), 32'd0);
    check("rst_addr", iomem_addr, 32'd0);
    check("rst_wdata", iomem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    // 1: write, responder ready after one wait cycle.
    resp_delay = 1;
    do_write(32'h0300_0000, 32'h0000_00A5, 1'b1);
    wait_idle("write_idle");
    check("write_len", 32'(last_len), 32'd2);

    // 2: read, zero-wait responder.
    resp_delay = 0;
    do_read(32'h0300_0000, 32'hDEAD_BEEF, 1'b1);
    wait_idle("read_idle");
    check("read_len", 32'(last_len), 32'd1);
    check("read_busy", 32'(busy), 32'd0);

    // Unaligned address is forced to a word address.
    resp_delay = 2;
    do_write(32'h0300_0107, 32'h1234_5678, 1'b1);
    wait_idle("unaligned_idle");

    // 3: bad opcode, then a normal read.
    base = txn_count;
    tx_q.push_back(8'h3F);
    send_byte(8'h55);
    wait_idle("bad_idle");
    check("bad_no_bus", 32'(txn_count), 32'(base));
    resp_delay = 0;
    do_read(32'h0300_0010, 32'hCAFE_F00D, 1'b1);
    wait_idle("after_bad_idle");

    // 4: tx backpressure during read reply.
    tx_hold = 1'b1;
    do_read(32'h0300_0004, 32'hDEAD_BEEF, 1'b1);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_tx_data", 32'(tx_data), 32'hDE);
      check("bp_rx_ready", 32'(rx_ready), 32'd0);
    end
    tx_hold = 1'b0;
    wait_idle("bp_idle");

    // 5: unresponsive slave.
`ifdef IOMEM_DBG_TIMEOUT_EN
    resp_delay = -1;
    do_read(32'h0300_0020, 32'h5555_AAAA, 1'b0);
    tx_q.push_back(8'h54);
    wait_idle("tmo_idle");
    check("tmo_len", 32'(last_len), 32'd16);
`else
    resp_delay = 40;
    do_read(32'h0300_0020, 32'h5555_AAAA, 1'b1);
    wait_idle("notmo_idle");
    check("notmo_len", 32'(last_len), 32'd41);
`endif

    // 6: reset in the middle of a bus cycle.
    resp_delay = -1;
    do_write(32'h0300_0030, 32'h0BAD_0BAD, 1'b0);
    n = 0;
    while (!in_txn && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pre_rst_valid", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(iomem_valid), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    resp_delay = 0;
    do_write(32'h0300_0040, 32'hA5A5_5A5A, 1'b1);
    wait_idle("post_rst_idle");
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
